// File: rtl/mult4_seq_ctrl.sv
// Sequential shift-and-add 4x4 unsigned multiplier sharing one 4-bit ripple adder.
// Optional MULT_ZERO_SKIP_EN: a zero operand jumps straight from IDLE to DONE.

module fulladder4 (
    input  logic [3:0] InputA,
    input  logic [3:0] InputB,
    input  logic       Ci,
    output logic [3:0] S,
    output logic       Co
);
    logic carry;

    always_comb begin
        carry = Ci;
        S     = 4'd0;
        for (int i = 0; i < 4; i++) begin
            S[i]  = InputA[i] ^ InputB[i] ^ carry;
            carry = (InputA[i] & InputB[i]) | (carry & (InputA[i] ^ InputB[i]));
        end
        Co = carry;
    end
endmodule

module mult4_seq_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_next;
    logic [3:0]  m;
    logic [3:0]  acc;
    logic [3:0]  q;
    logic        carry;
    logic [1:0]  cnt;
    logic [3:0]  sum;
    logic        co;
    logic        zero_op;

    fulladder4 adder (
        .InputA (acc),
        .InputB (m),
        .Ci     (1'b0),
        .S      (sum),
        .Co     (co)
    );

`ifdef MULT_ZERO_SKIP_EN
    assign zero_op = (a == 4'd0) || (b == 4'd0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = zero_op ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: the adder's carry-out becomes the top accumulator bit after each shift.
    always_ff @(posedge clock) begin
        if (reset) begin
            m       <= 4'd0;
            acc     <= 4'd0;
            q       <= 4'd0;
            carry   <= 1'b0;
            cnt     <= 2'd0;
            product <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= a;
                        q     <= zero_op ? 4'd0 : b;
                        acc   <= 4'd0;
                        carry <= 1'b0;
                        cnt   <= 2'd0;
                    end
                end
                RUN: begin
                    if (q[0]) begin
                        acc <= {co, sum[3:1]};
                        q   <= {sum[0], q[3:1]};
                    end else begin
                        acc <= {carry, acc[3:1]};
                        q   <= {acc[0], q[3:1]};
                    end
                    carry <= 1'b0;
                    cnt   <= cnt + 2'd1;
                end
                DONE: begin
                    product <= {acc, q};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Self-checking bench for mult4_seq_ctrl: directed cases plus random operands
// against a product/latency reference model (honours MULT_ZERO_SKIP_EN).

module tb_mult4_seq_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] prev_product = 8'd0;

    mult4_seq_ctrl dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_latency(input logic [3:0] ta, input logic [3:0] tb);
`ifdef MULT_ZERO_SKIP_EN
        if (ta == 4'd0 || tb == 4'd0) return 1;
`endif
        return 5;
    endfunction

    // Called just after a negedge; start is sampled at the next posedge (edge N).
    // hold keeps start high with a=b=1 for the whole operation.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input bit hold, input string tag);
        int lat;
        logic [7:0] expv;
        lat  = model_latency(ta, tb);
        expv = 8'(ta * tb);
        start = 1'b1;
        a = ta;
        b = tb;
        @(posedge clock);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clock);
            if (hold) begin
                a = 4'd1;
                b = 4'd1;
            end else begin
                start = 1'b0;
                a = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
            end
            if (k <= lat) begin
                chk({tag, "_busy"}, busy, 1);
                chk({tag, "_done"}, done, (k == lat) ? 1 : 0);
                chk({tag, "_hold"}, product, prev_product);
            end else begin
                chk({tag, "_idle_busy"}, busy, 0);
                chk({tag, "_idle_done"}, done, 0);
                chk({tag, "_product"}, product, expv);
            end
        end
        prev_product = expv;
    endtask

    initial begin
        logic [3:0] ra, rb;

        // Reset for two cycles, then idle three cycles.
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_product", product, 8'h00);
        end

        run_op(4'd3, 4'd5, 1'b0, "mul3x5");
        run_op(4'd15, 4'd15, 1'b0, "mul15x15");
        run_op(4'd9, 4'd6, 1'b0, "mul9x6");

        // Start held high: ignored while busy, new op taken right after DONE.
        run_op(4'd12, 4'd11, 1'b1, "hold");
        run_op(4'd1, 4'd1, 1'b0, "hold_next");

        // Reset during RUN discards the operation.
        @(negedge clock);
        start = 1'b1;
        a = 4'd7;
        b = 4'd7;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_product", product, 8'h00);
        prev_product = 8'h00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("midrst_nodone", done, 0);
            chk("midrst_nobusy", busy, 0);
        end

        run_op(4'd0, 4'd9, 1'b0, "zero_a");
        run_op(4'd13, 4'd0, 1'b0, "zero_b");

        for (int i = 0; i < 24; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            run_op(ra, rb, 1'b0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
